fg_cr_writer: RTL and testbench

- Host-side initiator for the function generator's configuration-register write port.
- Takes a 64-bit configuration image plus an 8-bit register mask and serialises it into write transactions on the 8-bit data / 3-bit address / write-strobe interface.
- The strobe is captured through a SYNC_STAGES-deep synchronizer at the responder, which writes while its synchronised enable is high.
- Used in bring-up/test fixtures and in multi-chip setups where one design configures another.

---
 rtl/fg_cr_writer.sv | 144 ++++++++++++++
 tb/tb_fg_cr_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fg_cr_writer.sv
// Configuration-register write initiator: walks the set bits of an 8-bit mask and
// issues one setup/strobe/hold write per register on the addr/data/wr interface.
module fg_cr_writer #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [63:0] cfg_i,
  input  logic [7:0]  mask_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  data_o,
  output logic [2:0]  addr_o,
  output logic        wr_o
);

  localparam int MAXC  = (SETUP_CYCLES > STROBE_CYCLES)
                       ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                       : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("fg_cr_writer: SETUP_CYCLES must be >= 1");
  end
  if (STROBE_CYCLES < SYNC_STAGES + 1) begin : g_bad_strobe
    $error("fg_cr_writer: STROBE_CYCLES must be >= SYNC_STAGES+1");
  end
  if (HOLD_CYCLES < SYNC_STAGES + 1) begin : g_bad_hold
    $error("fg_cr_writer: HOLD_CYCLES must be >= SYNC_STAGES+1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [63:0]       cfg_q;
  logic [7:0]        rem_q;
  logic              pend_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        data_q;
  logic [2:0]        addr_q;
  logic              wr_q;
  logic [2:0]        sel_idx_d;

  // Bits are cleared from rem_q as they are issued, so its lowest set bit is always
  // the next register above the current one.
  always_comb begin
    sel_idx_d = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_q[i]) sel_idx_d = 3'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      rem_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (pend_q) begin
            pend_q <= 1'b0;
            if (|rem_q) begin
              addr_q         <= sel_idx_d;
              data_q         <= cfg_q[{~sel_idx_d, 3'b000} +: 8];
              rem_q[sel_idx_d] <= 1'b0;
              busy_q         <= 1'b1;
              cnt_q          <= CNT_W'(SETUP_CYCLES - 1);
              state_q        <= SETUP;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else if (start_i) begin
            cfg_q  <= cfg_i;
            rem_q  <= mask_i;
            pend_q <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            wr_q    <= 1'b1;
            cnt_q   <= CNT_W'(STROBE_CYCLES - 1);
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            wr_q    <= 1'b0;
            cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            if (|rem_q) begin
              addr_q           <= sel_idx_d;
              data_q           <= cfg_q[{~sel_idx_d, 3'b000} +: 8];
              rem_q[sel_idx_d] <= 1'b0;
              cnt_q            <= CNT_W'(SETUP_CYCLES - 1);
              state_q          <= SETUP;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign data_o = data_q;
  assign addr_o = addr_q;
  assign wr_o   = wr_q;

endmodule

// File: tb/tb_fg_cr_writer.sv
// Bench for fg_cr_writer: vector table of write sequences, a scoreboard of expected
// strobes, and a 2-stage-synchronised responder model holding CR0..CR7.
module tb_fg_cr_writer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic [63:0] cfg_i;
  logic [7:0]  mask_i;
  logic        busy_o, done_o, wr_o;
  logic [7:0]  data_o;
  logic [2:0]  addr_o;

  fg_cr_writer dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .cfg_i(cfg_i), .mask_i(mask_i),
    .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .addr_o(addr_o), .wr_o(wr_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // responder: 2-stage synchronised strobe, writes while synchronised enable is high
  logic [1:0] rsp_sync = '0;
  logic [7:0] rsp_cr [8];
  logic       rsp_clr = 1'b0;
  always @(posedge clk_i) begin
    rsp_sync <= {rsp_sync[0], wr_o};
    if (rsp_clr) begin
      for (int i = 0; i < 8; i++) rsp_cr[i] <= 8'h00;
    end else if (rsp_sync[1]) begin
      rsp_cr[addr_o] <= data_o;
    end
  end

  logic wr_prev = 1'b0;
  int   rise_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  always @(negedge clk_i) begin
    exp_t it;
    if (wr_o && !wr_prev) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        it = sb.pop_front();
        chk("wr_addr", addr_o, it.addr);
        chk("wr_data", data_o, it.data);
        chk("wr_rise_cycle", cyc, it.cyc);
      end
      rise_cyc = cyc;
    end
    if (!wr_o && wr_prev && rstn_i) chk("wr_width", cyc - rise_cyc, 4);
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    wr_prev = wr_o;
  end

  task automatic clear_rsp();
    rsp_clr = 1'b1;
    @(negedge clk_i);
    rsp_clr = 1'b0;
  endtask

  // Runs one sequence; k is the edge that samples start_i.
  task automatic run_seq(input logic [63:0] cfg, input logic [7:0] mask, input bit inj);
    int k, n, bad_busy;
    logic [7:0] exp_cr [8];
    clear_rsp();
    k = cyc + 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      exp_cr[i] = 8'h00;
      if (mask[i]) begin
        exp_cr[i] = cfg[63 - 8*i -: 8];
        sb.push_back('{addr: 3'(i), data: cfg[63 - 8*i -: 8], cyc: k + 3 + 10*n});
        n++;
      end
    end
    done_cnt = 0;
    done_cyc = -1;
    bad_busy = 0;
    start_i = 1'b1; cfg_i = cfg; mask_i = mask;
    @(negedge clk_i);
    start_i = 1'b0; cfg_i = {$urandom, $urandom}; mask_i = 8'($urandom);
    for (int t = 0; t < n*10 + 12; t++) begin
      if (inj && cyc == k + 19) begin
        start_i = 1'b1; cfg_i = ~cfg; mask_i = 8'hFF;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      if (busy_o !== ((n > 0) && (cyc >= k + 1) && (cyc <= k + n*10))) bad_busy++;
    end
    start_i = 1'b0;
    chk("busy_profile_errors", bad_busy, 0);
    chk("done_pulse_count", done_cnt, 1);
    chk("done_cycle", done_cyc - k, 1 + n*10);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
    for (int i = 0; i < 8; i++) chk($sformatf("rsp_cr%0d", i), rsp_cr[i], exp_cr[i]);
  endtask

  typedef struct {
    logic [63:0] cfg;
    logic [7:0]  mask;
    bit          inj;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int k;
    vecs[0] = '{cfg: 64'h0123456789ABCDEF, mask: 8'hFF,        inj: 1'b0};
    vecs[1] = '{cfg: 64'h0123456789ABCDEF, mask: 8'b1000_0101, inj: 1'b0};
    vecs[2] = '{cfg: 64'h0123456789ABCDEF, mask: 8'h00,        inj: 1'b0};
    vecs[3] = '{cfg: 64'hFEDCBA9876543210, mask: 8'hFF,        inj: 1'b1};
    vecs[4] = '{cfg: 64'hA5C3_0F1E_7788_99B4, mask: 8'h80,     inj: 1'b0};
    vecs[5] = '{cfg: 64'h1122_3344_5566_7788, mask: 8'h5A,     inj: 1'b0};

    rstn_i = 1'b0; start_i = 1'b0; cfg_i = '0; mask_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wr", wr_o, 0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    for (int v = 0; v < 6; v++) run_seq(vecs[v].cfg, vecs[v].mask, vecs[v].inj);

    // reset during the 2nd strobe cycle of the addr-3 write
    clear_rsp();
    k = cyc + 1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{addr: 3'(i), data: vecs[0].cfg[63 - 8*i -: 8], cyc: k + 3 + 10*i});
    done_cnt = 0;
    start_i = 1'b1; cfg_i = vecs[0].cfg; mask_i = 8'hFF;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int t = 0; t < 60 && cyc < k + 34; t++) @(negedge clk_i);
    chk("pre_reset_wr", wr_o, 1);
    chk("pre_reset_addr", addr_o, 3);
    rstn_i = 1'b0;
    #1;
    chk("async_rst_wr", wr_o, 0);
    chk("async_rst_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_sb_drained", sb.size(), 0);
    sb.delete();
    rstn_i = 1'b1;
    @(negedge clk_i);
    run_seq(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
